// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port identifiers are used for grant history, lock ownership and response routing.
package memory_arbiter_pkg;

  localparam int WS_W      = 3;
  localparam int SEC_BYTE0 = 0;  // bits [7:0]
  localparam int SEC_BYTE1 = 1;  // bits [15:8]
  localparam int SEC_HALF1 = 2;  // bits [31:16]

  localparam logic [WS_W-1:0] WS_READ = '0;
  localparam logic [WS_W-1:0] WS_ALL  =
    WS_W'((1 << SEC_BYTE0) | (1 << SEC_BYTE1) | (1 << SEC_HALF1));

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_A    = 2'd1,
    PORT_B    = 2'd2
  } port_e;

endpackage

// File: rtl/memory_arbiter_rr_grant.sv
// Combinational two-way grant: a single requester always wins; on a tie the
// lock owner wins, otherwise the port that was not granted last.
module memory_arbiter_rr_grant
  import memory_arbiter_pkg::*;
(
  input  logic  reset,
  input  logic  a_valid,
  input  logic  b_valid,
  input  port_e last_grant,
  input  port_e owner,
  output logic  grant_a,
  output logic  grant_b
);

  // NOTE: every output gets a default first so no path through the block
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (a_valid && b_valid) begin
        if (owner == PORT_A) begin
          grant_a = 1'b1;
        end else if (owner == PORT_B) begin
          grant_b = 1'b1;
        end else if (last_grant == PORT_A) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory data port between two masters, with a
// bounded lock for uninterrupted multi-word sequences and 1-cycle response routing.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOCK_CYCLES = 16
) (
  input  logic            clk24,
  input  logic            reset,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic            a_lock,
  input  logic [31:0]     a_address,
  input  logic [31:0]     a_write_value,
  input  logic [WS_W-1:0] a_write_sections,
  output logic            a_resp_valid,
  output logic [31:0]     a_read_value,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic            b_lock,
  input  logic [31:0]     b_address,
  input  logic [31:0]     b_write_value,
  input  logic [WS_W-1:0] b_write_sections,
  output logic            b_resp_valid,
  output logic [31:0]     b_read_value,
  output logic            mem_enable,
  output logic [31:0]     mem_address,
  output logic [31:0]     mem_write_value,
  output logic [WS_W-1:0] mem_write_sections,
  input  logic [31:0]     mem_read_value
);

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK_CYCLES);

  port_e      last_grant_q, last_grant_d;
  port_e      owner_q, owner_d;
  port_e      resp_owner_q, resp_owner_d;
  logic [7:0] lock_count_q, lock_count_d, lock_base;

  logic  grant_a, grant_b, accept, acc_lock, other_valid;
  port_e granted;

  memory_arbiter_rr_grant u_grant (
    .reset      (reset),
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .last_grant (last_grant_q),
    .owner      (owner_q),
    .grant_a    (grant_a),
    .grant_b    (grant_b)
  );

  assign accept      = grant_a | grant_b;
  assign granted     = grant_a ? PORT_A : (grant_b ? PORT_B : PORT_NONE);
  assign acc_lock    = grant_a ? a_lock : b_lock;
  assign other_valid = grant_a ? b_valid : a_valid;

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign mem_enable         = accept;
  assign mem_address        = grant_b ? b_address : a_address;
  assign mem_write_value    = grant_b ? b_write_value : a_write_value;
  assign mem_write_sections = grant_a ? a_write_sections :
                              (grant_b ? b_write_sections : WS_READ);

  assign a_resp_valid = (resp_owner_q == PORT_A);
  assign b_resp_valid = (resp_owner_q == PORT_B);
  assign a_read_value = mem_read_value;
  assign b_read_value = mem_read_value;

  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    lock_count_d = lock_count_q;
    resp_owner_d = PORT_NONE;
    // A change of ownership starts the fairness count afresh.
    lock_base    = (owner_q == granted) ? lock_count_q : 8'd0;
    if (accept) begin
      resp_owner_d = granted;
      last_grant_d = granted;
      if (!acc_lock) begin
        owner_d      = PORT_NONE;
        lock_count_d = 8'd0;
      end else if (!other_valid) begin
        owner_d      = granted;
        lock_count_d = lock_base;
      end else if (lock_base + 8'd1 == LOCK_MAX) begin
        // Limit reached: drop the lock so the waiting port wins the next tie.
        owner_d      = PORT_NONE;
        lock_count_d = 8'd0;
      end else begin
        owner_d      = granted;
        lock_count_d = lock_base + 8'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk24) begin
    if (reset) begin
      last_grant_q <= PORT_B;
      owner_q      <= PORT_NONE;
      lock_count_q <= 8'd0;
      resp_owner_q <= PORT_NONE;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      lock_count_q <= lock_count_d;
      resp_owner_q <= resp_owner_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: per-feature tasks with inline checks
// plus a response scoreboard fed on every accept and drained on every response.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

  logic        clk24 = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, a_lock, a_resp_valid;
  logic [31:0] a_address, a_write_value, a_read_value;
  logic [2:0]  a_write_sections;
  logic        b_valid, b_ready, b_lock, b_resp_valid;
  logic [31:0] b_address, b_write_value, b_read_value;
  logic [2:0]  b_write_sections;
  logic        mem_enable;
  logic [31:0] mem_address, mem_write_value;
  logic [2:0]  mem_write_sections;
  logic [31:0] mem_read_value = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    port_e       port;
    logic [31:0] data;
    logic        is_read;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic        s_a_ready, s_b_ready, s_a_rv, s_b_rv, s_mem_en;
  logic [31:0] s_mem_addr, s_mem_wval, s_a_rdata, s_b_rdata;
  logic [2:0]  s_mem_ws;

  always #5 clk24 = ~clk24;

  memory_arbiter #(.MAX_LOCK_CYCLES(4)) dut (
    .clk24(clk24), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_lock(a_lock), .a_address(a_address),
    .a_write_value(a_write_value), .a_write_sections(a_write_sections),
    .a_resp_valid(a_resp_valid), .a_read_value(a_read_value),
    .b_valid(b_valid), .b_ready(b_ready), .b_lock(b_lock), .b_address(b_address),
    .b_write_value(b_write_value), .b_write_sections(b_write_sections),
    .b_resp_valid(b_resp_valid), .b_read_value(b_read_value),
    .mem_enable(mem_enable), .mem_address(mem_address), .mem_write_value(mem_write_value),
    .mem_write_sections(mem_write_sections), .mem_read_value(mem_read_value)
  );

  // Memory model: reads return a fixed function of the address one cycle later.
  always @(posedge clk24)
    if (mem_enable)
      mem_read_value <= (mem_write_sections == 3'b000) ? (mem_address ^ RD_KEY) : 32'hDEAD_BEEF;

  function automatic port_e observed_grant();
    return s_a_ready ? PORT_A : (s_b_ready ? PORT_B : PORT_NONE);
  endfunction

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
    a_write_sections = 3'b000; b_write_sections = 3'b000;
  endtask

  // One clock cycle: sample at negedge, run the scoreboard, advance past posedge.
  task automatic step();
    exp_t  e;
    port_e rp;
    @(negedge clk24);
    s_a_ready = a_ready;   s_b_ready = b_ready;
    s_a_rv = a_resp_valid; s_b_rv = b_resp_valid;
    s_a_rdata = a_read_value; s_b_rdata = b_read_value;
    s_mem_en = mem_enable; s_mem_addr = mem_address;
    s_mem_wval = mem_write_value; s_mem_ws = mem_write_sections;
    n_cmp++;
    if (s_a_ready === 1'b1 && s_b_ready === 1'b1) begin
      n_err++;
      $display("FAIL one_grant cyc=%0d got a_ready=1 b_ready=1 expected at most one", cyc);
    end
    if (s_a_rv === 1'b1 || s_b_rv === 1'b1) begin
      n_cmp++;
      rp = s_a_rv ? PORT_A : PORT_B;
      if (sb.size() == 0 || sb[0].due != cyc) begin
        n_err++;
        $display("FAIL sb_unexpected cyc=%0d got response on %s expected none", cyc, rp.name());
      end else begin
        e = sb.pop_front();
        if ((s_a_rv && s_b_rv) || rp != e.port ||
            (e.is_read && ((rp == PORT_A ? s_a_rdata : s_b_rdata) !== e.data))) begin
          n_err++;
          $display("FAIL sb_resp cyc=%0d got a_rv=%b b_rv=%b data=%h expected %s data=%h",
                   cyc, s_a_rv, s_b_rv, (rp == PORT_A ? s_a_rdata : s_b_rdata),
                   e.port.name(), e.data);
        end
      end
    end else if (sb.size() != 0 && sb[0].due == cyc) begin
      n_cmp++; n_err++;
      $display("FAIL sb_missing cyc=%0d got no response expected %s", cyc, sb[0].port.name());
      void'(sb.pop_front());
    end
    if (a_valid && s_a_ready === 1'b1) begin
      e = '{port: PORT_A, data: a_address ^ RD_KEY, is_read: (a_write_sections == 3'b000), due: cyc + 1};
      sb.push_back(e);
    end
    if (b_valid && s_b_ready === 1'b1) begin
      e = '{port: PORT_B, data: b_address ^ RD_KEY, is_read: (b_write_sections == 3'b000), due: cyc + 1};
      sb.push_back(e);
    end
    @(posedge clk24);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    a_valid = 1'b1; b_valid = 1'b1;
    a_address = 32'h0; b_address = 32'h0; a_write_value = '0; b_write_value = '0;
    step();
    n_cmp++;
    if ({s_a_ready, s_b_ready, s_a_rv, s_b_rv, s_mem_en, s_mem_ws} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_outputs got rdy=%b%b rv=%b%b en=%b ws=%b expected all 0",
               s_a_ready, s_b_ready, s_a_rv, s_b_rv, s_mem_en, s_mem_ws);
    end
    idle();
    reset = 1'b0;
  endtask

  task automatic test_first_tie();
    a_valid = 1'b1; b_valid = 1'b1; a_address = 32'h10; b_address = 32'h20;
    step();
    n_cmp++;
    if (observed_grant() !== PORT_A || s_mem_addr !== 32'h10 || s_mem_ws !== 3'b000) begin
      n_err++;
      $display("FAIL tie_first got grant=%s addr=%h ws=%b expected PORT_A addr=00000010 ws=000",
               observed_grant().name(), s_mem_addr, s_mem_ws);
    end
    a_valid = 1'b0;
    step();
    n_cmp++;
    if (observed_grant() !== PORT_B || s_mem_addr !== 32'h20 || s_a_rv !== 1'b1) begin
      n_err++;
      $display("FAIL tie_second got grant=%s addr=%h a_rv=%b expected PORT_B addr=00000020 a_rv=1",
               observed_grant().name(), s_mem_addr, s_a_rv);
    end
    idle();
    step();
    n_cmp++;
    if (s_b_rv !== 1'b1 || s_a_rv !== 1'b0) begin
      n_err++;
      $display("FAIL tie_b_resp got a_rv=%b b_rv=%b expected a_rv=0 b_rv=1", s_a_rv, s_b_rv);
    end
  endtask

  task automatic test_contention();
    port_e exp_p;
    a_valid = 1'b1; b_valid = 1'b1; a_address = 32'h100; b_address = 32'h200;
    for (int i = 0; i < 6; i++) begin
      exp_p = (i % 2 == 0) ? PORT_A : PORT_B;
      step();
      n_cmp++;
      if (observed_grant() !== exp_p || s_mem_en !== 1'b1) begin
        n_err++;
        $display("FAIL contention[%0d] got grant=%s en=%b expected %s en=1",
                 i, observed_grant().name(), s_mem_en, exp_p.name());
      end
      if (s_a_ready) a_address = a_address + 32'd4;
      if (s_b_ready) b_address = b_address + 32'd4;
    end
    idle();
    step();
  endtask

  task automatic test_lock_write();
    b_valid = 1'b1; b_address = 32'h300;
    a_valid = 1'b1; a_lock = 1'b1; a_address = 32'h8000_0008;
    a_write_value = 32'h1111_2222; a_write_sections = WS_ALL;
    step();
    n_cmp++;
    if (observed_grant() !== PORT_A || s_mem_addr !== 32'h8000_0008 ||
        s_mem_ws !== 3'b111 || s_mem_wval !== 32'h1111_2222) begin
      n_err++;
      $display("FAIL lock_w0 got grant=%s addr=%h ws=%b wval=%h expected PORT_A 80000008 111 11112222",
               observed_grant().name(), s_mem_addr, s_mem_ws, s_mem_wval);
    end
    a_lock = 1'b0; a_address = 32'h8000_000C; a_write_value = 32'h3333_4444;
    step();
    n_cmp++;
    if (observed_grant() !== PORT_A || s_mem_addr !== 32'h8000_000C || s_mem_ws !== 3'b111) begin
      n_err++;
      $display("FAIL lock_w1 got grant=%s addr=%h ws=%b expected PORT_A 8000000c 111",
               observed_grant().name(), s_mem_addr, s_mem_ws);
    end
    a_valid = 1'b1; a_address = 32'h400; a_write_sections = 3'b000;
    step();
    n_cmp++;
    if (observed_grant() !== PORT_B || s_mem_addr !== 32'h300) begin
      n_err++;
      $display("FAIL lock_release got grant=%s addr=%h expected PORT_B 00000300",
               observed_grant().name(), s_mem_addr);
    end
    idle();
    step();
    step();
  endtask

  task automatic test_lock_limit();
    port_e exp_p;
    a_valid = 1'b1; a_lock = 1'b1; a_address = 32'h500;
    b_valid = 1'b1; b_lock = 1'b0; b_address = 32'h600;
    for (int i = 0; i < 10; i++) begin
      exp_p = (i % 5 == 4) ? PORT_B : PORT_A;
      step();
      n_cmp++;
      if (observed_grant() !== exp_p) begin
        n_err++;
        $display("FAIL lock_limit[%0d] got grant=%s expected %s",
                 i, observed_grant().name(), exp_p.name());
      end
      if (s_a_ready) a_address = a_address + 32'd4;
      if (s_b_ready) b_address = b_address + 32'd4;
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    a_valid = 1'b1; a_address = 32'h40;
    step();
    n_cmp++;
    if (observed_grant() !== PORT_A) begin
      n_err++;
      $display("FAIL rstmid_accept got grant=%s expected PORT_A", observed_grant().name());
    end
    idle();
    reset = 1'b1;
    step();
    n_cmp++;
    if (s_a_rv !== 1'b1 || s_a_rdata !== (32'h40 ^ RD_KEY)) begin
      n_err++;
      $display("FAIL rstmid_resp got a_rv=%b data=%h expected a_rv=1 data=%h",
               s_a_rv, s_a_rdata, 32'h40 ^ RD_KEY);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if ({s_a_ready, s_b_ready, s_a_rv, s_b_rv, s_mem_en, s_mem_ws} !== 8'b0) begin
      n_err++;
      $display("FAIL rstmid_quiet got rdy=%b%b rv=%b%b en=%b ws=%b expected all 0",
               s_a_ready, s_b_ready, s_a_rv, s_b_rv, s_mem_en, s_mem_ws);
    end
    a_valid = 1'b1; b_valid = 1'b1; a_address = 32'h50; b_address = 32'h60;
    step();
    n_cmp++;
    if (observed_grant() !== PORT_A || s_mem_addr !== 32'h50) begin
      n_err++;
      $display("FAIL rstmid_tie got grant=%s addr=%h expected PORT_A 00000050",
               observed_grant().name(), s_mem_addr);
    end
    a_valid = 1'b0;
    step();
    idle();
    step();
  endtask

  task automatic test_b_alone();
    b_valid = 1'b1; b_address = 32'h70; b_write_value = 32'h0000_00AB;
    b_write_sections = 3'b001;
    step();
    n_cmp++;
    if (s_b_ready !== 1'b1 || s_mem_ws !== 3'b001 || s_mem_addr !== 32'h70 ||
        s_mem_wval !== 32'h0000_00AB) begin
      n_err++;
      $display("FAIL b_write got rdy=%b ws=%b addr=%h wval=%h expected 1 001 00000070 000000ab",
               s_b_ready, s_mem_ws, s_mem_addr, s_mem_wval);
    end
    b_address = 32'h74; b_write_sections = 3'b000;
    step();
    n_cmp++;
    if (s_b_ready !== 1'b1 || s_b_rv !== 1'b1 || s_mem_ws !== 3'b000) begin
      n_err++;
      $display("FAIL b_read got rdy=%b b_rv=%b ws=%b expected 1 1 000", s_b_ready, s_b_rv, s_mem_ws);
    end
    idle();
    step();
    n_cmp++;
    if (s_b_rv !== 1'b1 || s_b_rdata !== (32'h74 ^ RD_KEY)) begin
      n_err++;
      $display("FAIL b_read_resp got b_rv=%b data=%h expected 1 %h", s_b_rv, s_b_rdata, 32'h74 ^ RD_KEY);
    end
  endtask

  initial begin
    test_reset();
    test_first_tie();
    test_contention();
    test_lock_write();
    test_lock_limit();
    test_reset_mid();
    test_b_alone();
    step();
    step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d pending responses expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port round-robin arbiter that shares the single data port of the on-chip block RAM / memory-mapped register space between the core data port (port A) and a second bus master (port B: loader/debug). It sits between the requesters and the memory decode in the top level. It presents one transaction per cycle to the memory side and routes the one-cycle-latency read data back to the issuing port. A bounded lock lets one master perform uninterrupted multi-word sequences, such as split 64-bit mtime/mtimecmp updates.

## Interface
Parameters:
- MAX_LOCK_CYCLES, 16: maximum consecutive grants a locking port may hold while the other port is waiting; range 1..255.

Ports:
- clk24  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- a_valid, b_valid  in  1  request present.
- a_ready, b_ready  out  1  request accepted this cycle (valid && ready = accept).
- a_lock, b_lock  in  1  keep the grant for the next request; sampled on accept.
- a_address, b_address  in  32  byte address.
- a_write_value, b_write_value  in  32  write data, already lane-aligned.
- a_write_sections, b_write_sections  in  3  write enables: bit0 = [7:0], bit1 = [15:8], bit2 = [31:16]; 0 = read.
- a_resp_valid, b_resp_valid  out  1  response for the port's previous accept.
- a_read_value, b_read_value  out  32  both driven from mem_read_value; qualified by *_resp_valid.
- mem_enable  out  1  transaction issued this cycle.
- mem_address  out  32  muxed address.
- mem_write_value  out  32  muxed write data.
- mem_write_sections  out  3  muxed write enables; forced 0 when no accept.
- mem_read_value  in  32  memory data, valid the cycle after issue.

## Operation
- Grant is computed combinationally each cycle from a_valid, b_valid and state. Exactly one or zero of a_ready/b_ready is high. ready may depend on valid.
- Only one valid: that port is granted.
- Both valid, no active lock: grant goes to the port not granted last (last_grant register).
- Lock state: owner (none/A/B), lock_count (8 bit).
  - On accept with owner's *_lock=1: owner := granted port.
  - On accept with *_lock=0: owner := none, lock_count := 0.
- While owner = X and X valid: X wins ties.
  - lock_count increments on each grant to X while the other port is valid; it holds otherwise.
  - When lock_count reaches MAX_LOCK_CYCLES, lock_count clears, owner clears, and the other port is granted next cycle if valid.
- If the owner drops valid, the other port may be granted. The lock is released (owner := none) only if the other port is accepted.
- On accept: mem_enable=1, and mem_* is copied from the granted port. With no accept, mem_enable=0, mem_write_sections=0, and address/data hold the A-port values (don't care).
- Response: resp_owner register, captured on accept. In cycle N+1 exactly the issuing port's *_resp_valid=1, including for writes (acknowledgement; read_value is don't care).
- Requesters must hold address, write_value, write_sections and lock stable while valid && !ready.

## Timing
- Reset values: a_ready=b_ready=0, a_resp_valid=b_resp_valid=0, mem_enable=0, mem_write_sections=0, last_grant=B (A wins the first tie), owner=none, lock_count=0.
- While reset=1: all readies are 0 and no accept occurs.
- Latency: accept in cycle N gives resp_valid in cycle N+1. Throughput is 1 transaction/cycle, and back-to-back grants to the same port are allowed.
- Reset asserted in cycle N+1 after an accept in cycle N: the response still appears in N+1, because resp_valid is registered from cycle N. Reset at the N+1 edge clears resp_owner, so no response appears in N+2.
- Simultaneous release and contention: a lock=0 accept by A with B waiting makes B win the next cycle.
- lock_count saturates by clearing; it never wraps past MAX_LOCK_CYCLES.

## Structure
- Shared package: write-section width (3), section bit positions, port-ID enum {PORT_NONE, PORT_A, PORT_B}.
- One sub-module, rr_grant: combinational 2-way grant from valids, last_grant and owner/lock_count. The top holds the registers, the mux and the response routing.

## Test plan
- After reset, A and B both valid reads of 0x10 / 0x20: cycle 0 grants A (mem_address=0x10), cycle 1 grants B. a_resp_valid is in cycle 1 and b_resp_valid in cycle 2, each with the returned data.
- Continuous contention over 6 cycles: grants alternate A,B,A,B,A,B with no idle cycles.
- A writes 0x80000008 then 0x8000000C with a_lock=1, then a_lock=0, while B is valid throughout: A gets both words consecutively, then B is granted. mem_write_sections=3'b111 on both writes.
- A locks continuously with MAX_LOCK_CYCLES=4 and B valid: A gets 4 grants, B gets 1, then A resumes.
- Reset pulse in the cycle after an A accept: a_resp_valid=1 in that cycle, all outputs are 0 the following cycle, and the first post-reset tie goes to A.
- B alone issues a write_sections=3'b001 write followed by a read: ready is 1 both cycles, and b_resp_valid=1 in the following two cycles.
